// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int unsigned NUM_SETS_DEF = 16;
  localparam int unsigned LINE_W_DEF   = 256;
  localparam int unsigned ADDR_W_DEF   = 32;

  localparam int unsigned OFF_W  = 5;
  localparam int unsigned IDX_W  = $clog2(NUM_SETS_DEF);
  localparam int unsigned TAG_W  = ADDR_W_DEF - OFF_W - IDX_W;
  localparam int unsigned WSEL_W = $clog2(LINE_W_DEF / 32);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_if.sv
// CPU-side request/response and memory-side line handshake of the data cache.
interface dcache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              cpu_req_i;
  logic              cpu_write_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;
  logic              mem_req_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  // Cache side.
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Pipeline/memory environment side.
  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Tag and data arrays: combinational read, word-merge store port, full-line refill port.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = NUM_SETS_DEF,
  parameter int unsigned LINE_W   = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output tag_entry_t        rd_entry,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   line_q [NUM_SETS];

  // Valid/dirty flags: cleared by reset, set by refill (clean) or store (dirty).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and line storage: no reset, contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (word_we) begin
      line_q[idx][{word_sel, 5'b0} +: 32] <= word_data;
    end
  end

  // Asynchronous read of the addressed set.
  always_comb begin
    rd_entry.valid = valid_q[idx];
    rd_entry.dirty = dirty_q[idx];
    rd_entry.tag   = tag_q[idx];
    rd_line        = line_q[idx];
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 D-cache controller (FSM, address split, hit logic).
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = NUM_SETS_DEF,
  parameter int unsigned LINE_W   = LINE_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input logic   clk_i,
  input logic   rst_i,
  dcache_if.slave bus
);

  state_t state_q, state_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  tag_entry_t        entry;
  logic [LINE_W-1:0] line;
  logic              hit, miss;
  logic              word_we, fill_we;
  logic              stall, mem_req, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data;
  logic              unused_addr_lsb;

  assign req_idx         = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag         = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel        = bus.cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

  dcache_sram #(
    .NUM_SETS (NUM_SETS),
    .LINE_W   (LINE_W)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (req_idx),
    .rd_entry  (entry),
    .rd_line   (line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (bus.cpu_data_i),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (bus.mem_data_i)
  );

  assign hit  = bus.cpu_req_i & entry.valid & (entry.tag == req_tag);
  assign miss = bus.cpu_req_i & ~hit;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a miss evicts through WRITEBACK only when the victim is dirty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (miss) state_d = (entry.valid && entry.dirty) ? WRITEBACK : REFILL;
      WRITEBACK: if (bus.mem_ack_i) state_d = REFILL;
      REFILL:    if (bus.mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs and array write strobes; reset forces the handshake quiet.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    word_we   = 1'b0;
    fill_we   = 1'b0;
    case (state_q)
      IDLE: begin
        stall   = miss;
        word_we = hit & bus.cpu_write_i;
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {entry.tag, req_idx, {OFF_W{1'b0}}};
        mem_data  = line;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        fill_we  = bus.mem_ack_i;
      end
      default: ;
    endcase
    if (rst_i) begin
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      word_we   = 1'b0;
      fill_we   = 1'b0;
    end
  end

  assign bus.cpu_data_o  = line[{word_sel, 5'b0} +: 32];
  assign bus.cpu_stall_o = stall;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_write_o = mem_write;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_data_o  = mem_data;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: directed vector table, reset corner sequences, randomized traffic vs. a set-level model.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  dcache_controller #(
    .NUM_SETS (16),
    .LINE_W   (256),
    .ADDR_W   (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [255:0] mem_lines [int unsigned];
  bit prev_req = 0;
  bit prev_ack = 0;

  function automatic logic [255:0] pat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int unsigned w = 0; w < 8; w++) l[w*32 +: 32] = {la[23:0], 8'(w)} ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] la);
    if (mem_lines.exists(la)) return mem_lines[la];
    return pat_line(la);
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle of the memory responder; call with inputs already driven in the low phase.
  task automatic mem_cycle(input int lwb, input int lrf, inout int cnt,
                           inout int nwb, inout logic [31:0] wb_a, inout logic [255:0] wb_l,
                           inout int nrf, inout logic [31:0] rf_a);
    bit ack;
    ack = 0;
    if (bus.mem_req_o) begin
      if (!prev_req || prev_ack) begin
        cnt = 1;
        if (bus.mem_write_o) begin nwb++; wb_a = bus.mem_addr_o; wb_l = bus.mem_data_o; end
        else begin nrf++; rf_a = bus.mem_addr_o; end
      end else cnt++;
      ack = (cnt == (bus.mem_write_o ? lwb : lrf));
      if (ack) begin
        if (bus.mem_write_o) mem_lines[bus.mem_addr_o] = bus.mem_data_o;
        else bus.mem_data_i = mem_read(bus.mem_addr_o);
      end
    end
    bus.mem_ack_i = ack;
    prev_req = bus.mem_req_o;
    prev_ack = ack;
    @(posedge clk);
    @(negedge clk);
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int lwb, input int lrf,
                        output int stalls, output int nwb, output logic [31:0] wb_a,
                        output logic [255:0] wb_l, output int nrf, output logic [31:0] rf_a,
                        output logic [31:0] rdata, output bit timeout);
    int cnt;
    stalls = 0; nwb = 0; nrf = 0; wb_a = '0; wb_l = '0; rf_a = '0; rdata = '0;
    timeout = 1; cnt = 0;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = wr;
    bus.cpu_addr_i  = a;
    bus.cpu_data_i  = d;
    for (int c = 0; c < 200; c++) begin
      #2;
      if (!bus.cpu_stall_o) begin
        rdata = bus.cpu_data_o;
        timeout = 0;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      stalls++;
      mem_cycle(lwb, lrf, cnt, nwb, wb_a, wb_l, nrf, rf_a);
    end
  endtask

  task automatic do_reset();
    bus.cpu_req_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_req = 0;
    prev_ack = 0;
  endtask

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  data;
    int           lwb, lrf;
    int           exp_stall, exp_nwb, exp_nrf;
    logic [31:0]  exp_wb_addr;
    logic [255:0] exp_wb_line;
    logic [31:0]  exp_rf_addr;
    bit           chk_rd;
    logic [31:0]  exp_rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [31:0] d, int lwb, int lrf,
                              int st, int nwb, logic [31:0] wba, logic [255:0] wbl,
                              int nrf, logic [31:0] rfa, bit crd, logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.lwb = lwb; v.lrf = lrf;
    v.exp_stall = st; v.exp_nwb = nwb; v.exp_wb_addr = wba; v.exp_wb_line = wbl;
    v.exp_nrf = nrf; v.exp_rf_addr = rfa; v.chk_rd = crd; v.exp_rd = rd;
    return v;
  endfunction

  task automatic check_access(input string tag, input vec_t v);
    int st, nwb, nrf;
    logic [31:0] wba, rfa, rd;
    logic [255:0] wbl;
    bit to;
    access(v.wr, v.addr, v.data, v.lwb, v.lrf, st, nwb, wba, wbl, nrf, rfa, rd, to);
    chk_int({tag, ".timeout"}, int'(to), 0);
    chk_int({tag, ".stall_cycles"}, st, v.exp_stall);
    chk_int({tag, ".writebacks"}, nwb, v.exp_nwb);
    if (v.exp_nwb > 0 && nwb > 0) begin
      chk_vec({tag, ".wb_addr"}, 256'(wba), 256'(v.exp_wb_addr));
      chk_vec({tag, ".wb_line"}, wbl, v.exp_wb_line);
    end
    chk_int({tag, ".refills"}, nrf, v.exp_nrf);
    if (v.exp_nrf > 0 && nrf > 0) chk_vec({tag, ".rf_addr"}, 256'(rfa), 256'(v.exp_rf_addr));
    if (v.chk_rd) chk_vec({tag, ".rdata"}, 256'(rd), 256'(v.exp_rd));
  endtask

  // Reference model state (one entry per set).
  bit           rv [16];
  bit           rdty [16];
  logic [22:0]  rt [16];
  logic [255:0] rl [16];

  initial begin
    logic [255:0] l100, l100w, l100w2, l20, l20w, l300, l1020;
    vec_t v;
    int cnt, nwb, nrf;
    logic [31:0] wba, rfa;
    logic [255:0] wbl;

    rst = 1'b1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0000_0100;
    bus.cpu_data_i  = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_data_i  = '0;

    // Reset with a pending request: stall and mem_req stay low.
    @(negedge clk);
    #2;
    chk_int("rst.stall", int'(bus.cpu_stall_o), 0);
    chk_int("rst.mem_req", int'(bus.mem_req_o), 0);
    chk_int("rst.mem_write", int'(bus.mem_write_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req_i = 1'b0;
    #2;
    chk_int("post_rst.stall", int'(bus.cpu_stall_o), 0);
    chk_vec("post_rst.mem_addr", 256'(bus.mem_addr_o), '0);
    @(negedge clk);

    l100 = pat_line(32'h100);
    l100w = l100;  l100w[95:64] = 32'hDEADBEEF;
    l100w2 = l100w; l100w2[127:96] = 32'h0BADF00D;
    l20 = pat_line(32'h20);
    l20w = l20;    l20w[63:32] = 32'h1234_5678;
    l300 = pat_line(32'h300);
    l1020 = pat_line(32'h1020);

    vt.push_back(mk(0, 32'h100,  0,            0, 5, 6, 0, 0,      0,      1, 32'h100,  1, l100[31:0]));
    vt.push_back(mk(0, 32'h104,  0,            0, 1, 0, 0, 0,      0,      0, 0,        1, l100[63:32]));
    vt.push_back(mk(1, 32'h108,  32'hDEADBEEF, 0, 1, 0, 0, 0,      0,      0, 0,        0, 0));
    vt.push_back(mk(0, 32'h108,  0,            0, 1, 0, 0, 0,      0,      0, 0,        1, 32'hDEADBEEF));
    vt.push_back(mk(0, 32'h300,  0,            3, 2, 6, 1, 32'h100, l100w, 1, 32'h300,  1, l300[31:0]));
    vt.push_back(mk(1, 32'h24,   32'h12345678, 0, 1, 2, 0, 0,      0,      1, 32'h20,   0, 0));
    vt.push_back(mk(0, 32'h24,   0,            0, 1, 0, 0, 0,      0,      0, 0,        1, 32'h12345678));
    vt.push_back(mk(0, 32'h20,   0,            0, 1, 0, 0, 0,      0,      0, 0,        1, l20[31:0]));
    vt.push_back(mk(0, 32'h1020, 0,            2, 2, 5, 1, 32'h20, l20w,   1, 32'h1020, 1, l1020[31:0]));
    vt.push_back(mk(0, 32'h300,  0,            0, 1, 0, 0, 0,      0,      0, 0,        1, l300[31:0]));
    vt.push_back(mk(0, 32'h108,  0,            0, 3, 4, 0, 0,      0,      1, 32'h100,  1, 32'hDEADBEEF));
    vt.push_back(mk(1, 32'h10C,  32'h0BADF00D, 0, 1, 0, 0, 0,      0,      0, 0,        0, 0));
    vt.push_back(mk(0, 32'h300,  0,            1, 1, 3, 1, 32'h100, l100w2, 1, 32'h300, 1, l300[31:0]));

    foreach (vt[i]) check_access($sformatf("vec%0d", i), vt[i]);

    // Idle: memory handshake outputs are zero.
    bus.cpu_req_i = 1'b0;
    #2;
    chk_int("idle.mem_req", int'(bus.mem_req_o), 0);
    chk_int("idle.mem_write", int'(bus.mem_write_o), 0);
    chk_vec("idle.mem_addr", 256'(bus.mem_addr_o), '0);
    chk_vec("idle.mem_data", bus.mem_data_o, '0);
    @(negedge clk);

    // Reset in the middle of a refill.
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = 1'b0; bus.cpu_addr_i = 32'h500;
    #2;
    chk_int("midrst.miss_stall", int'(bus.cpu_stall_o), 1);
    @(negedge clk);
    #2;
    chk_int("midrst.refill_req", int'(bus.mem_req_o), 1);
    chk_vec("midrst.refill_addr", 256'(bus.mem_addr_o), 256'(32'h500));
    chk_int("midrst.refill_write", int'(bus.mem_write_o), 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk_int("midrst.rst_mem_req", int'(bus.mem_req_o), 0);
    chk_int("midrst.rst_stall", int'(bus.cpu_stall_o), 0);
    @(negedge clk);
    rst = 1'b0; bus.cpu_req_i = 1'b0; prev_req = 0; prev_ack = 0;
    bus.mem_ack_i = 1'b1;
    bus.mem_data_i = {8{32'hFFFF_FFFF}};
    @(negedge clk);
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    #2;
    chk_int("stray_ack.mem_req", int'(bus.mem_req_o), 0);
    chk_int("stray_ack.stall", int'(bus.cpu_stall_o), 0);
    @(negedge clk);
    check_access("after_rst300", mk(0, 32'h300, 0, 4, 2, 3, 0, 0, 0, 1, 32'h300, 1, l300[31:0]));
    check_access("after_rst1020", mk(0, 32'h1020, 0, 4, 1, 2, 0, 0, 0, 1, 32'h1020, 1, l1020[31:0]));

    // Randomized traffic against a set-level model.
    do_reset();
    for (int s = 0; s < 16; s++) begin rv[s] = 0; rdty[s] = 0; rt[s] = '0; rl[s] = '0; end
    for (int n = 0; n < 80; n++) begin
      int unsigned t, ix, w;
      logic [31:0] a, lineaddr;
      t  = $urandom_range(0, 3);
      ix = $urandom_range(0, 3);
      w  = $urandom_range(0, 7);
      a  = (t << 9) | (ix << 5) | (w << 2);
      lineaddr = a & 32'hFFFF_FFE0;
      v = mk($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4),
             0, 0, 0, 0, 0, 0, 0, 0);
      if (!(rv[ix] && rt[ix] == 23'(t))) begin
        if (rv[ix] && rdty[ix]) begin
          v.exp_nwb = 1;
          v.exp_wb_addr = ({9'd0, rt[ix]} << 9) | (ix << 5);
          v.exp_wb_line = rl[ix];
          v.exp_stall = v.lwb;
        end
        v.exp_stall += v.lrf + 1;
        v.exp_nrf = 1;
        v.exp_rf_addr = lineaddr;
        rv[ix] = 1; rdty[ix] = 0; rt[ix] = 23'(t);
        rl[ix] = mem_read(lineaddr);
      end
      if (v.wr) begin
        rl[ix][w*32 +: 32] = v.data;
        rdty[ix] = 1;
      end else begin
        v.chk_rd = 1;
        v.exp_rd = rl[ix][w*32 +: 32];
      end
      check_access($sformatf("rnd%0d", n), v);
      if ($urandom_range(0, 3) == 0) begin
        bus.cpu_req_i = 1'b0;
        cnt = 0; nwb = 0; nrf = 0; wba = '0; rfa = '0; wbl = '0;
        #2;
        mem_cycle(1, 1, cnt, nwb, wba, wbl, nrf, rfa);
        chk_int($sformatf("rnd%0d.idle_mem_req", n), nwb + nrf, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
